// File: rtl/sd_defs.sv
// Shared definitions for the sigma-delta chain: CIC order, accumulator width derivation and
// the bitstream-to-signed-unit mapping.
package sd_defs;

    localparam int unsigned CIC_ORDER = 3;

    // One bit of growth per stage per decimation bit, plus sign and headroom for +/-DECIM**N.
    function automatic int unsigned cic_acc_w(input int unsigned log2_decim);
        return CIC_ORDER * log2_decim + 2;
    endfunction

    function automatic logic signed [1:0] bit_to_pm1(input logic b);
        return b ? 2'sb01 : 2'sb11;
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// Single wrapping CIC integrator stage: acc += in on every enabled cycle, modulo 2**W.
module cic_integrator #(
    parameter int unsigned W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic signed [W-1:0] in_i,
    output logic signed [W-1:0] acc_o
);

    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + in_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/sd_cic_decimator.sv
// Third-order CIC decimator for a 1-bit sigma-delta bitstream; emits one signed sample per
// 2**LOG2_DECIM qualified input bits with a single-cycle valid strobe after warm-up.
module sd_cic_decimator
    import sd_defs::*;
#(
    parameter  int unsigned LOG2_DECIM = 6,
    localparam int unsigned ACC_W      = cic_acc_w(LOG2_DECIM)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sd_en,
    input  logic                    sd_in,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_valid
);

    logic signed [1:0]       pm;
    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] i1, i2, i3;

    always_comb begin
        pm = bit_to_pm1(sd_in);
        x  = {{(ACC_W-2){pm[1]}}, pm};
    end

    cic_integrator #(.W(ACC_W)) u_int1 (
        .clk   (clk),
        .reset (reset),
        .en_i  (sd_en),
        .in_i  (x),
        .acc_o (i1)
    );

    cic_integrator #(.W(ACC_W)) u_int2 (
        .clk   (clk),
        .reset (reset),
        .en_i  (sd_en),
        .in_i  (i1),
        .acc_o (i2)
    );

    cic_integrator #(.W(ACC_W)) u_int3 (
        .clk   (clk),
        .reset (reset),
        .en_i  (sd_en),
        .in_i  (i2),
        .acc_o (i3)
    );

    logic [LOG2_DECIM-1:0]   cnt_q, cnt_d;
    logic                    tick_q, tick_d;
    logic [1:0]              settle_q, settle_d;
    logic signed [ACC_W-1:0] s_d_q, s_d_d;
    logic signed [ACC_W-1:0] c1_d_q, c1_d_d;
    logic signed [ACC_W-1:0] c2_d_q, c2_d_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] c1, c2, c3;
    logic                    strobe;

    // Comb path wraps just like the integrators, so the difference stays exact.
    always_comb begin
        strobe = sd_en && (cnt_q == {LOG2_DECIM{1'b1}});
        cnt_d  = sd_en ? cnt_q + 1'b1 : cnt_q;
        tick_d = strobe;

        c1 = i3 - s_d_q;
        c2 = c1 - c1_d_q;
        c3 = c2 - c2_d_q;

        s_d_d       = s_d_q;
        c1_d_d      = c1_d_q;
        c2_d_d      = c2_d_q;
        out_data_d  = out_data_q;
        settle_d    = settle_q;
        out_valid_d = 1'b0;
        if (tick_q) begin
            s_d_d       = i3;
            c1_d_d      = c1;
            c2_d_d      = c2;
            out_data_d  = c3;
            out_valid_d = (settle_q == 2'd3);
            if (settle_q != 2'd3) begin
                settle_d = settle_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            settle_q    <= '0;
            s_d_q       <= '0;
            c1_d_q      <= '0;
            c2_d_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            settle_q    <= settle_d;
            s_d_q       <= s_d_d;
            c1_d_q      <= c1_d_d;
            c2_d_q      <= c2_d_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
